// File: rtl/sram_controller_pkg.sv
// Shared definitions for the SRAM controller.
// Contents: FSM state encoding, SRAM data/address widths, and the default
// byte address that maps to SRAM word 0.
package sram_controller_pkg;

  localparam int SRAM_DW = 16;           // SRAM data bus width
  localparam int SRAM_AW = 18;           // SRAM half-word address width
  localparam int SRAM_IW = SRAM_AW - 1;  // 32-bit word index width

  localparam logic [31:0] SRAM_MEM_BASE = 32'd1024;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    DONE = 2'd3
  } sram_state_e;

endpackage

// File: rtl/sram_phase_counter.sv
// 4-bit phase counter for the SRAM controller.
// Ports:
//   clk, rst : clock and synchronous active-high reset
//   load     : reload the count to 0 (phase entry)
//   last     : terminal count value
//   count    : current count
//   tc       : count has reached last; the counter parks there until reloaded
module sram_phase_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] last,
  output logic [3:0] count,
  output logic       tc
);

  assign tc = (count == last);

  always_ff @(posedge clk) begin
    if (rst || load) count <= '0;
    else if (!tc)    count <= count + 4'd1;
  end

endmodule

// File: rtl/sram_controller.sv
// MEM-stage to 16-bit SRAM bridge. Each 32-bit access is split into a low
// half (even half-word address) and a high half (odd half-word address),
// each lasting HALF_CYCLES clocks. The pipeline is frozen (ready=0) until
// the access reaches DONE.
// Ports:
//   clk, rst              : clock and synchronous active-high reset
//   mem_read, mem_write   : level requests, held until ready
//   address, write_data   : byte address and store data
//   read_data             : load result, held until the next load
//   ready                 : pipeline may advance
//   sram_addr             : SRAM half-word address
//   sram_dq_out/_in/_oe   : SRAM data out, data in, drive enable
//   sram_we_n             : SRAM write enable, active-low
module sram_controller
  import sram_controller_pkg::*;
#(
  parameter int unsigned HALF_CYCLES = 2,
  parameter logic [31:0] MEM_BASE    = SRAM_MEM_BASE
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mem_read,
  input  logic               mem_write,
  input  logic [31:0]        address,
  input  logic [31:0]        write_data,
  output logic [31:0]        read_data,
  output logic               ready,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [SRAM_DW-1:0] sram_dq_out,
  input  logic [SRAM_DW-1:0] sram_dq_in,
  output logic               sram_dq_oe,
  output logic               sram_we_n
);

  localparam logic [3:0] LAST = 4'(HALF_CYCLES - 1);

  sram_state_e        state_q, state_d;
  logic               req;
  logic [3:0]         phase_cnt;
  logic               phase_tc, phase_load;
  logic               acc_write;
  logic [SRAM_IW-1:0] acc_idx, idx_new;
  logic [31:0]        acc_data;
  logic               unused_addr_bits;

  assign req = mem_read | mem_write;

  // Word index of (address - MEM_BASE) >> 2, modulo 2^17. MEM_BASE is
  // word aligned, so the low two bits never borrow and only bits 18:2 of
  // each operand matter.
  assign idx_new          = address[18:2] - MEM_BASE[18:2];
  assign unused_addr_bits = ^{address[31:19], address[1:0]};

  // ---- state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // ---- next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req)      state_d = LOW;
      LOW:     if (phase_tc) state_d = HIGH;
      HIGH:    if (phase_tc) state_d = DONE;
      default:               state_d = IDLE;
    endcase
  end

  // ---- outputs
  always_comb begin
    ready = 1'b0;
    if (rst)                   ready = !req;
    else if (state_q == DONE)  ready = 1'b1;
    else if (state_q == IDLE)  ready = !req;
  end

  // Hold the counter at 0 outside LOW/HIGH so each phase starts from 0.
  assign phase_load = (state_q != state_d) || (state_q == IDLE) || (state_q == DONE);

  sram_phase_counter u_phase (
    .clk   (clk),
    .rst   (rst),
    .load  (phase_load),
    .last  (LAST),
    .count (phase_cnt),
    .tc    (phase_tc)
  );

  // SRAM pins and captured access are registered on phase transitions so
  // they are stable for the whole phase and hold in IDLE/DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_write   <= 1'b0;
      acc_idx     <= '0;
      acc_data    <= '0;
      read_data   <= '0;
      sram_addr   <= '0;
      sram_dq_out <= '0;
      sram_dq_oe  <= 1'b0;
      sram_we_n   <= 1'b1;
    end else begin
      case (state_q)
        IDLE: if (req) begin
          acc_write <= mem_write;  // write wins when both are requested
          acc_idx   <= idx_new;
          acc_data  <= write_data;
          sram_addr <= {idx_new, 1'b0};
          if (mem_write) begin
            sram_dq_out <= write_data[15:0];
            sram_dq_oe  <= 1'b1;
            sram_we_n   <= 1'b0;
          end
        end
        LOW: if (phase_tc) begin
          sram_addr <= {acc_idx, 1'b1};
          if (acc_write) sram_dq_out     <= acc_data[31:16];
          else           read_data[15:0] <= sram_dq_in;
        end
        HIGH: if (phase_tc) begin
          sram_dq_oe <= 1'b0;
          sram_we_n  <= 1'b1;
          if (!acc_write) read_data[31:16] <= sram_dq_in;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_controller.sv
// Directed self-checking bench for sram_controller: one instance with
// HALF_CYCLES=2 backed by a small SRAM model, one with HALF_CYCLES=1 fed
// a constant data pattern.
module tb_sram_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        mem_read, mem_write;
  logic [31:0] address, write_data, read_data;
  logic        ready;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out, sram_dq_in;
  logic        sram_dq_oe, sram_we_n;

  logic        h1_mem_read, h1_mem_write;
  logic [31:0] h1_address, h1_write_data, h1_read_data;
  logic        h1_ready;
  logic [17:0] h1_sram_addr;
  logic [15:0] h1_dq_out, h1_dq_in;
  logic        h1_dq_oe, h1_we_n;

  int errors = 0;
  int checks = 0;
  int lows;

  sram_controller #(.HALF_CYCLES(2)) u_dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
    .address(address), .write_data(write_data), .read_data(read_data),
    .ready(ready), .sram_addr(sram_addr), .sram_dq_out(sram_dq_out),
    .sram_dq_in(sram_dq_in), .sram_dq_oe(sram_dq_oe), .sram_we_n(sram_we_n)
  );

  sram_controller #(.HALF_CYCLES(1), .MEM_BASE(32'd1024)) u_h1 (
    .clk(clk), .rst(rst), .mem_read(h1_mem_read), .mem_write(h1_mem_write),
    .address(h1_address), .write_data(h1_write_data), .read_data(h1_read_data),
    .ready(h1_ready), .sram_addr(h1_sram_addr), .sram_dq_out(h1_dq_out),
    .sram_dq_in(h1_dq_in), .sram_dq_oe(h1_dq_oe), .sram_we_n(h1_we_n)
  );

  // Asynchronous-read SRAM model; writes land on every edge with we_n low.
  logic [15:0] mem [0:1023];
  logic        pre_en;
  logic [9:0]  pre_a;
  logic [15:0] pre_d;
  always @(posedge clk) begin
    if (pre_en)          mem[pre_a] <= pre_d;
    else if (!sram_we_n) mem[sram_addr[9:0]] <= sram_dq_out;
  end
  assign sram_dq_in = mem[sram_addr[9:0]];
  assign h1_dq_in   = 16'hA5A5;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [9:0] a, input logic [15:0] d);
    pre_en = 1'b1; pre_a = a; pre_d = d;
    tick();
    pre_en = 1'b0;
  endtask

  // Raise the request and advance until ready; returns in the DONE cycle
  // with the request still asserted.
  task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] d, output int n);
    mem_read = rd; mem_write = wr; address = a; write_data = d;
    n = 0;
    #1;
    while (ready !== 1'b1 && n < 64) begin
      n++;
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    mem_read = 1'b0; mem_write = 1'b0; address = '0; write_data = '0;
    h1_mem_read = 1'b0; h1_mem_write = 1'b0; h1_address = '0; h1_write_data = '0;
    pre_en = 1'b0; pre_a = '0; pre_d = '0;

    // ---- reset state
    tick(); tick();
    chk("rst_ready",   32'(ready), 32'd1);
    chk("rst_we_n",    32'(sram_we_n), 32'd1);
    chk("rst_oe",      32'(sram_dq_oe), 32'd0);
    chk("rst_addr",    32'(sram_addr), 32'd0);
    chk("rst_dq_out",  32'(sram_dq_out), 32'd0);
    chk("rst_rdata",   read_data, 32'd0);
    chk("rst_h1_ready", 32'(h1_ready), 32'd1);
    rst = 1'b0;
    tick();

    // ---- store 0xDEADBEEF at 0x404 (word 1 -> half-words 2,3)
    mem_write = 1'b1; address = 32'h404; write_data = 32'hDEADBEEF;
    #1;
    chk("st_c0_ready", 32'(ready), 32'd0);
    for (int c = 1; c <= 4; c++) begin
      tick();
      chk("st_ready", 32'(ready), 32'd0);
      chk("st_addr",  32'(sram_addr), (c <= 2) ? 32'd2 : 32'd3);
      chk("st_dq",    32'(sram_dq_out), (c <= 2) ? 32'hBEEF : 32'hDEAD);
      chk("st_we_n",  32'(sram_we_n), 32'd0);
      chk("st_oe",    32'(sram_dq_oe), 32'd1);
    end
    tick();
    chk("st_done_ready", 32'(ready), 32'd1);
    chk("st_done_we_n",  32'(sram_we_n), 32'd1);
    chk("st_done_oe",    32'(sram_dq_oe), 32'd0);
    mem_write = 1'b0;
    tick();
    chk("st_idle_ready", 32'(ready), 32'd1);
    chk("st_mem2", 32'(mem[2]), 32'hBEEF);
    chk("st_mem3", 32'(mem[3]), 32'hDEAD);

    // ---- load back from 0x404, then 10 idle cycles of stable read_data
    access(1'b1, 1'b0, 32'h404, 32'h0, lows);
    chk("ld_lows",  32'(lows), 32'd5);
    chk("ld_rdata", read_data, 32'hDEADBEEF);
    mem_read = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("ld_hold", read_data, 32'hDEADBEEF);
    end

    // ---- back-to-back loads 0x400 then 0x408
    poke(10'd0, 16'h1111); poke(10'd1, 16'h2222);
    poke(10'd4, 16'h3333); poke(10'd5, 16'h4444);
    mem_read = 1'b1; address = 32'h400;
    #1;
    chk("bb_c0_ready", 32'(ready), 32'd0);
    tick(); chk("bb_c1_addr", 32'(sram_addr), 32'd0);
    tick();
    tick(); chk("bb_c3_addr", 32'(sram_addr), 32'd1);
    tick();
    tick(); chk("bb_c5_ready", 32'(ready), 32'd1);
    chk("bb_c5_rdata", read_data, 32'h22221111);
    address = 32'h408;
    tick(); chk("bb_c6_ready", 32'(ready), 32'd0);
    chk("bb_c6_addr", 32'(sram_addr), 32'd1);
    tick(); chk("bb_c7_addr", 32'(sram_addr), 32'd4);
    tick();
    tick(); chk("bb_c9_addr", 32'(sram_addr), 32'd5);
    tick(); chk("bb_c10_ready", 32'(ready), 32'd0);
    tick(); chk("bb_c11_ready", 32'(ready), 32'd1);
    chk("bb_c11_rdata", read_data, 32'h44443333);
    mem_read = 1'b0;
    tick();

    // ---- reset in the second HIGH cycle of a write
    mem_write = 1'b1; address = 32'h404; write_data = 32'hCAFEF00D;
    tick(); tick(); tick(); tick();
    chk("rw_high_addr", 32'(sram_addr), 32'd3);
    rst = 1'b1; mem_write = 1'b0;
    tick();
    chk("rw_we_n",  32'(sram_we_n), 32'd1);
    chk("rw_oe",    32'(sram_dq_oe), 32'd0);
    chk("rw_ready", 32'(ready), 32'd1);
    chk("rw_addr",  32'(sram_addr), 32'd0);
    chk("rw_rdata", read_data, 32'd0);
    rst = 1'b0;
    tick();
    access(1'b1, 1'b0, 32'h404, 32'h0, lows);
    chk("rw_ld_lows",  32'(lows), 32'd5);
    chk("rw_ld_rdata", read_data, 32'hCAFEF00D);
    mem_read = 1'b0;
    tick();
    chk("rw_mem1", 32'(mem[1]), 32'h2222);
    chk("rw_mem4", 32'(mem[4]), 32'h3333);

    // ---- read and write together: the write wins, read_data untouched
    access(1'b1, 1'b1, 32'h408, 32'h55667788, lows);
    chk("both_lows",  32'(lows), 32'd5);
    chk("both_rdata", read_data, 32'hCAFEF00D);
    mem_read = 1'b0; mem_write = 1'b0;
    tick();
    chk("both_mem4", 32'(mem[4]), 32'h7788);
    chk("both_mem5", 32'(mem[5]), 32'h5566);

    // ---- HALF_CYCLES=1: three-cycle freeze, then index wrap at address 0
    h1_mem_read = 1'b1; h1_address = 32'h400;
    #1;
    chk("h1_c0_ready", 32'(h1_ready), 32'd0);
    tick();
    chk("h1_c1_ready", 32'(h1_ready), 32'd0);
    chk("h1_c1_addr",  32'(h1_sram_addr), 32'd0);
    tick();
    chk("h1_c2_ready", 32'(h1_ready), 32'd0);
    chk("h1_c2_addr",  32'(h1_sram_addr), 32'd1);
    tick();
    chk("h1_c3_ready", 32'(h1_ready), 32'd1);
    chk("h1_rdata",    h1_read_data, 32'hA5A5A5A5);
    h1_address = 32'h0;
    tick();
    chk("h1_idle_ready", 32'(h1_ready), 32'd0);
    tick();
    chk("h1_wrap_lo", 32'(h1_sram_addr), 32'h3FE00);
    tick();
    chk("h1_wrap_hi", 32'(h1_sram_addr), 32'h3FE01);
    tick();
    chk("h1_wrap_ready", 32'(h1_ready), 32'd1);
    h1_mem_read = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
